// File: rtl/bsg_level_shift_sink_iso_ctrl_pkg.sv
// bsg_level_shift_pkg: shared types for the sink-side isolation controller
package bsg_level_shift_pkg;

    typedef enum logic [1:0] {eIso, eSettle, eActive} bsg_iso_state_e;

endpackage

// File: rtl/bsg_level_shift_sink_iso_ctrl_if.sv
// bsg_level_shift_sink_iso_ctrl_if: v0 data/power-good in, isolated v1 data out
interface bsg_level_shift_sink_iso_ctrl_if #(
    parameter int width_p        = 16,
    parameter int num_channels_p = 4
);
    logic [num_channels_p*width_p-1:0] v0_data_i;
    logic                              v0_pwr_good_i;
    logic [num_channels_p-1:0]         v1_en_i;
    logic [num_channels_p*width_p-1:0] v1_data_o;
    logic [num_channels_p-1:0]         v1_valid_o;
    logic                              v1_active_o;

    modport master (
        output v0_data_i, v0_pwr_good_i, v1_en_i,
        input  v1_data_o, v1_valid_o, v1_active_o
    );

    modport slave (
        input  v0_data_i, v0_pwr_good_i, v1_en_i,
        output v1_data_o, v1_valid_o, v1_active_o
    );
endinterface

// File: rtl/bsg_level_shift_sink_iso_ctrl_sync_2ff.sv
// bsg_iso_sync_2ff: two-flop reset-to-zero synchronizer for a single bit
module bsg_iso_sync_2ff (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] s_r;

    // shift the asynchronous input through two flops
    always_ff @(posedge clk_i)
        if (reset_i) s_r <= '0;
        else         s_r <= {s_r[0], d_i};

    assign q_o = s_r[1];
endmodule

// File: rtl/bsg_level_shift_sink_iso_ctrl.sv
// bsg_level_shift_sink_iso_ctrl: power-good sequenced isolation of v0 lanes into v1
module bsg_level_shift_sink_iso_ctrl
    import bsg_level_shift_pkg::*;
#(
    parameter int                 width_p         = 16,
    parameter int                 num_channels_p  = 4,
    parameter int                 settle_cycles_p = 8,
    parameter logic [width_p-1:0] clamp_val_p     = '0,
    parameter bit                 hold_last_p     = 1'b0
) (
    input logic                           clk_i,
    input logic                           reset_i,
    bsg_level_shift_sink_iso_ctrl_if.slave io
);
    localparam int cnt_w = (settle_cycles_p == 0) ? 1 : $clog2(settle_cycles_p + 1);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'((settle_cycles_p == 0) ? 0 : settle_cycles_p - 1);

    bsg_iso_state_e                    state_r, state_n;
    logic [cnt_w-1:0]                  cnt_r, cnt_n;
    logic                              pg_s;
    logic [num_channels_p-1:0]         pass;
    logic [num_channels_p-1:0]         valid_r;
    logic [num_channels_p*width_p-1:0] data_r;

    bsg_iso_sync_2ff sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (io.v0_pwr_good_i),
        .q_o    (pg_s)
    );

    // state and settle counter registers
    always_ff @(posedge clk_i)
        if (reset_i) begin
            state_r <= eIso;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end

    // sequencing: isolate until synced power-good has been stable for the settle window
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        unique case (state_r)
            eIso: begin
                cnt_n = '0;
                if (pg_s) state_n = (settle_cycles_p == 0) ? eActive : eSettle;
            end
            eSettle: begin
                if (!pg_s) begin
                    state_n = eIso;
                    cnt_n   = '0;
                end else if (cnt_r == last_cnt) state_n = eActive;
                else cnt_n = cnt_r + cnt_w'(1);
            end
            eActive: begin
                if (!pg_s) begin
                    state_n = eIso;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = eIso;
                cnt_n   = '0;
            end
        endcase
    end

    // per-lane pass decision from current state and outputs
    always_comb begin
        pass           = {num_channels_p{state_r == eActive}} & io.v1_en_i;
        io.v1_active_o = (state_r == eActive);
        io.v1_data_o   = data_r;
        io.v1_valid_o  = valid_r;
    end

    for (genvar c = 0; c < num_channels_p; c++) begin : lane
        logic [width_p-1:0] d_r;
        logic               v_r;

        // register v0 data when passing, otherwise clamp or hold
        always_ff @(posedge clk_i)
            if (reset_i) begin
                d_r <= clamp_val_p;
                v_r <= 1'b0;
            end else begin
                d_r <= pass[c] ? io.v0_data_i[c*width_p +: width_p] : (hold_last_p ? d_r : clamp_val_p);
                v_r <= pass[c];
            end

        assign data_r[c*width_p +: width_p] = d_r;
        assign valid_r[c]                   = v_r;
    end
endmodule

// File: tb/tb_bsg_level_shift_sink_iso_ctrl.sv
// tb_bsg_level_shift_sink_iso_ctrl: directed scoreboard bench for the isolation controller
module tb_bsg_level_shift_sink_iso_ctrl;
    localparam logic [15:0] clamp = 16'hC1A0;
    localparam logic [63:0] clamp4 = {4{clamp}};

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    bsg_level_shift_sink_iso_ctrl_if ia ();
    bsg_level_shift_sink_iso_ctrl_if ih ();
    bsg_level_shift_sink_iso_ctrl_if iz ();

    bsg_level_shift_sink_iso_ctrl #(.settle_cycles_p(8), .clamp_val_p(clamp), .hold_last_p(1'b0))
        dut_a (.clk_i(clk), .reset_i(reset), .io(ia.slave));
    bsg_level_shift_sink_iso_ctrl #(.settle_cycles_p(8), .clamp_val_p(clamp), .hold_last_p(1'b1))
        dut_h (.clk_i(clk), .reset_i(reset), .io(ih.slave));
    bsg_level_shift_sink_iso_ctrl #(.settle_cycles_p(0))
        dut_z (.clk_i(clk), .reset_i(reset), .io(iz.slave));

    always #5 clk = ~clk;

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(string t, logic [63:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic chk(logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(logic pg, logic [3:0] en, logic [63:0] d);
        ia.v0_pwr_good_i = pg;
        ih.v0_pwr_good_i = pg;
        ia.v1_en_i       = en;
        ih.v1_en_i       = en;
        ia.v0_data_i     = d;
        ih.v0_data_i     = d;
    endtask

    task automatic wait_active(string t);
        for (int i = 0; i < 10; i++) begin
            expect_v({t, "_early"}, 64'd0);
            step();
            chk(ia.v1_active_o | ia.v1_valid_o);
        end
        expect_v({t, "_active"}, 64'd1);
        step();
        chk(ia.v1_active_o);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 4'hF, 64'h4444_3333_2222_1111);
        iz.v0_pwr_good_i = 1'b0;
        iz.v1_en_i       = 4'h0;
        iz.v0_data_i     = '0;
        step(2);
        expect_v("rst_data", clamp4);        chk(ia.v1_data_o);
        expect_v("rst_hold_data", clamp4);   chk(ih.v1_data_o);
        expect_v("rst_valid", 64'd0);        chk(ia.v1_valid_o);
        expect_v("rst_active", 64'd0);       chk(ia.v1_active_o);

        reset = 1'b0;
        wait_active("t1");
        expect_v("t1_valid_first", 64'd0);   chk(ia.v1_valid_o);
        expect_v("t1_data", 64'h4444_3333_2222_1111);
        step();
        chk(ia.v1_data_o);
        expect_v("t1_valid", 64'hF);         chk(ia.v1_valid_o);

        iz.v0_pwr_good_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_v("t2_early", 64'd0);
            step();
            chk(iz.v1_active_o);
        end
        expect_v("t2_active", 64'd1);
        step();
        chk(iz.v1_active_o);
        iz.v0_data_i = 64'h0000_0000_0000_A5A5;
        iz.v1_en_i   = 4'h1;
        expect_v("t2_data", 64'h0000_0000_0000_A5A5);
        step();
        chk(iz.v1_data_o);
        expect_v("t2_valid", 64'h1);         chk(iz.v1_valid_o);

        drive(1'b1, 4'hF, 64'h4444_3333_2222_1234);
        expect_v("t4_pass", 64'h4444_3333_2222_1234);
        step();
        chk(ia.v1_data_o);
        drive(1'b0, 4'hF, 64'h4444_3333_2222_1234);
        expect_v("t4_clamp", clamp4);
        step(4);
        chk(ia.v1_data_o);
        expect_v("t4_hold", 64'h4444_3333_2222_1234); chk(ih.v1_data_o);
        expect_v("t4_valid", 64'd0);         chk(ia.v1_valid_o);
        expect_v("t4_hold_valid", 64'd0);    chk(ih.v1_valid_o);
        expect_v("t4_active", 64'd0);        chk(ia.v1_active_o);

        drive(1'b1, 4'hF, 64'h4444_3333_2222_1234);
        for (int i = 0; i < 6; i++) begin
            expect_v("t3_rise", 64'd0);
            step();
            chk(ia.v1_active_o | ia.v1_valid_o);
        end
        drive(1'b0, 4'hF, 64'h4444_3333_2222_1234);
        for (int i = 0; i < 6; i++) begin
            expect_v("t3_drop", 64'd0);
            step();
            chk(ia.v1_active_o | ia.v1_valid_o);
        end
        drive(1'b1, 4'hF, 64'h4444_3333_2222_1234);
        wait_active("t3_restart");

        drive(1'b1, 4'b0101, 64'hDDDD_CCCC_BBBB_AAAA);
        expect_v("t5_data", 64'hC1A0_CCCC_C1A0_AAAA);
        step();
        chk(ia.v1_data_o);
        expect_v("t5_valid", 64'h5);         chk(ia.v1_valid_o);
        drive(1'b1, 4'b0001, 64'hDDDD_CCCC_BBBB_AAAA);
        expect_v("t5_toggle_data", 64'hC1A0_C1A0_C1A0_AAAA);
        step();
        chk(ia.v1_data_o);
        expect_v("t5_toggle_valid", 64'h1);  chk(ia.v1_valid_o);

        reset = 1'b1;
        drive(1'b1, 4'hF, 64'hDDDD_CCCC_BBBB_AAAA);
        expect_v("t6_data", clamp4);
        step();
        chk(ia.v1_data_o);
        expect_v("t6_valid", 64'd0);         chk(ia.v1_valid_o);
        expect_v("t6_active", 64'd0);        chk(ia.v1_active_o);
        reset = 1'b0;
        wait_active("t6");
        expect_v("t6_pass", 64'hDDDD_CCCC_BBBB_AAAA);
        step();
        chk(ia.v1_data_o);
        expect_v("t6_pass_valid", 64'hF);    chk(ia.v1_valid_o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
